// File: rtl/apb_completer.sv
// APB4 completer endpoint: fixed wait-state insertion in front of a small
// register bank (ID, sampled hardware status, byte-strobed control registers).
module apb_completer #(
  parameter int unsigned          dataWidth  = 32,
  parameter int unsigned          addrWidth  = 32,
  parameter int unsigned          numRegs    = 16,
  parameter int unsigned          waitStates = 1,
  parameter logic [dataWidth-1:0] idValue    = 32'hA9B0_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [2:0]             pprot,
  input  logic [dataWidth/8-1:0] pstrb,
  input  logic [addrWidth-1:0]   paddr,
  input  logic [dataWidth-1:0]   pwdata,
  input  logic [dataWidth-1:0]   status_in,
  output logic                   pready,
  output logic [dataWidth-1:0]   prdata,
  output logic                   pslverr,
  output logic [dataWidth-1:0]   ctrl_out
);

  localparam int unsigned idxWidth  = $clog2(numRegs);
  localparam int unsigned strbWidth = dataWidth / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [3:0]           cnt;
  logic [idxWidth-1:0]  idx_q;
  logic                 oor_q;
  logic                 write_q;
  logic                 priv_q;
  logic [dataWidth-1:0] wdata_q;
  logic [strbWidth-1:0] strb_q;
  logic [dataWidth-1:0] regs [numRegs];

  logic                 setup;
  logic [idxWidth-1:0]  idx_in;
  logic                 oor_in;
  logic                 in_idle;
  logic [idxWidth-1:0]  eff_idx;
  logic                 eff_oor;
  logic                 eff_write;
  logic                 eff_priv;
  logic                 rsp_err;
  logic [dataWidth-1:0] rsp_data;
  logic                 entering_done;
  logic                 unused_bits;

  assign setup   = psel && !penable;
  assign idx_in  = paddr[idxWidth+1:2];
  assign oor_in  = |(paddr >> (idxWidth + 2));
  assign in_idle = (state == IDLE);

  // With zero wait states DONE is entered straight from the setup cycle,
  // before the latched copies exist, so the response is computed from the
  // live bus in IDLE and from the latched copies otherwise.
  assign eff_idx   = in_idle ? idx_in   : idx_q;
  assign eff_oor   = in_idle ? oor_in   : oor_q;
  assign eff_write = in_idle ? pwrite   : write_q;
  assign eff_priv  = in_idle ? pprot[0] : priv_q;

  assign entering_done = (state_next == DONE) && (state != DONE);

  assign pready   = (state == DONE);
  assign ctrl_out = regs[2];

  assign unused_bits = ^{paddr[1:0], pprot[2:1]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (setup) begin
          state_next = (waitStates == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_next = IDLE;
        end else if (cnt == 4'd1) begin
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wait-state counter: loaded on setup, counts down while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (in_idle && setup) begin
      cnt <= 4'(waitStates);
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Capture setup-phase request so access-phase bus changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      oor_q   <= 1'b0;
      write_q <= 1'b0;
      priv_q  <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (in_idle && setup) begin
      idx_q   <= idx_in;
      oor_q   <= oor_in;
      write_q <= pwrite;
      priv_q  <= pprot[0];
      wdata_q <= pwdata;
      strb_q  <= pstrb;
    end
  end

  // Response decode: error classification and read mux
  always_comb begin
    rsp_err  = eff_oor || (eff_write && ((eff_idx < idxWidth'(2)) || !eff_priv));
    rsp_data = '0;
    if (!rsp_err && !eff_write) begin
      if (eff_idx == idxWidth'(0)) begin
        rsp_data = idValue;
      end else if (eff_idx == idxWidth'(1)) begin
        rsp_data = status_in;
      end else begin
        rsp_data = regs[eff_idx];
      end
    end
  end

  // Response registers: loaded on entry to DONE, zero in every other state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else if (entering_done) begin
      prdata  <= rsp_data;
      pslverr <= rsp_err;
    end else begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end
  end

  // Register bank: byte-strobed commit on the completion edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < numRegs; i++) begin
        regs[i] <= '0;
      end
    end else if ((state == DONE) && write_q && !pslverr) begin
      for (int unsigned b = 0; b < strbWidth; b++) begin
        if (strb_q[b]) begin
          regs[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_completer.sv
// Testbench for apb_completer: one instance with one wait state, one with none.
module tb_apb_completer;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel_a = 1'b0;
  logic        psel_b = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [2:0]  pprot = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] status_in = '0;

  logic        pready_a, pslverr_a, pready_b, pslverr_b;
  logic [31:0] prdata_a, prdata_b, ctrl_a, ctrl_b;

  always #5 clk = ~clk;

  apb_completer #(
    .dataWidth(32), .addrWidth(32), .numRegs(16), .waitStates(1), .idValue(ID)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .pprot(pprot), .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata),
    .status_in(status_in), .pready(pready_a), .prdata(prdata_a),
    .pslverr(pslverr_a), .ctrl_out(ctrl_a)
  );

  apb_completer #(
    .dataWidth(32), .addrWidth(32), .numRegs(16), .waitStates(0), .idValue(ID)
  ) dut0 (
    .clk(clk), .rst(rst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .pprot(pprot), .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata),
    .status_in(status_in), .pready(pready_b), .prdata(prdata_b),
    .pslverr(pslverr_b), .ctrl_out(ctrl_b)
  );

  typedef struct {
    bit          wr;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][16];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic model_clear();
    for (int w = 0; w < 2; w++)
      for (int r = 0; r < 16; r++)
        model[w][r] = '0;
  endtask

  // Reference behaviour of one transfer; updates the model on a good write
  task automatic model_resp(input int unsigned which, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output exp_t e);
    int unsigned idx;
    bit oor;
    idx  = 32'(addr[5:2]);
    oor  = (addr[31:6] != '0);
    e.wr = wr;
    e.err = oor || (wr && (idx < 2 || !prot[0]));
    e.data = '0;
    if (!e.err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[which][idx][8*b +: 8] = wdata[8*b +: 8];
      end else if (idx == 0) begin
        e.data = ID;
      end else if (idx == 1) begin
        e.data = status_in;
      end else begin
        e.data = model[which][idx];
      end
    end
  endtask

  // One APB transfer; returns on the negedge of the completion cycle, psel left high
  task automatic apb_xfer(input int unsigned which, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot);
    exp_t e;
    exp_t got;
    int unsigned waits;
    int unsigned want_waits;
    bit done;
    waits = 0;
    done = 1'b0;
    want_waits = (which == 0) ? 1 : 0;
    @(posedge clk); #1;
    psel_a = (which == 0);
    psel_b = (which == 1);
    penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
    model_resp(which, wr, addr, wdata, strb, prot, e);
    sb.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    pwrite = ~wr; paddr = ~addr; pwdata = ~wdata; pstrb = ~strb; pprot = ~prot;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if ((which == 0) ? pready_a : pready_b) done = 1'b1;
      else waits++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL completion addr=%h: pready never rose, required within 20 cycles", addr);
      void'(sb.pop_front());
    end else begin
      got.data = (which == 0) ? prdata_a : prdata_b;
      got.err  = (which == 0) ? pslverr_a : pslverr_b;
      e = sb.pop_front();
      n_checks++;
      if (got.err !== e.err) begin
        n_fail++;
        $display("FAIL pslverr addr=%h wr=%0d: got %0d required %0d", addr, wr, got.err, e.err);
      end
      if (!e.wr || e.err) begin
        n_checks++;
        if (got.data !== e.data) begin
          n_fail++;
          $display("FAIL prdata addr=%h: got %h required %h", addr, got.data, e.data);
        end
      end
      n_checks++;
      if (waits !== want_waits) begin
        n_fail++;
        $display("FAIL latency dut%0d addr=%h: got %0d wait cycles required %0d", which, addr, waits, want_waits);
      end
    end
  endtask

  task automatic apb_idle();
    @(posedge clk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    n_checks++;
    if (pready_a !== 1'b0 || prdata_a !== '0 || pslverr_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got pready=%b prdata=%h pslverr=%b required 0/0/0", name, pready_a, prdata_a, pslverr_a);
    end
  endtask

  task automatic check_ctrl(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: ctrl_out got %h required %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_outputs");
    n_checks++;
    if (pready_b !== 1'b0 || prdata_b !== '0 || pslverr_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_ws0: got %b/%h/%b required 0/0/0", pready_b, prdata_b, pslverr_b);
    end
    check_ctrl("reset_ctrl_a", ctrl_a, 32'h0);
    check_ctrl("reset_ctrl_b", ctrl_b, 32'h0);
    rst = 1'b1;
  endtask

  task automatic test_read_id();
    apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    @(negedge clk);
    n_checks++;
    if (pready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL pready_one_cycle: got %b required 0", pready_a);
    end
    apb_xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    apb_idle();
  endtask

  task automatic test_write_strobes();
    apb_xfer(0, 1'b1, 32'h08, 32'h1234_5678, 4'b1111, 3'b001);
    check_ctrl("ctrl_before_commit", ctrl_a, 32'h0);
    @(posedge clk); #1;
    check_ctrl("ctrl_after_full_write", ctrl_a, 32'h1234_5678);
    apb_xfer(0, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'b0101, 3'b001);
    @(posedge clk); #1;
    check_ctrl("ctrl_after_strobe_write", ctrl_a, 32'h12FF_56FF);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000);
    apb_idle();
  endtask

  task automatic test_errors();
    status_in = 32'hDEAD_BEEF;
    apb_xfer(0, 1'b1, 32'h04, 32'h1111_1111, 4'hF, 3'b001);
    apb_xfer(0, 1'b1, 32'h08, 32'hAAAA_AAAA, 4'hF, 3'b000);
    @(posedge clk); #1;
    check_ctrl("ctrl_after_unpriv_write", ctrl_a, 32'h12FF_56FF);
    apb_xfer(0, 1'b1, 32'h00, 32'h2222_2222, 4'hF, 3'b001);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001);
    apb_xfer(0, 1'b1, 32'h7C, 32'h3333_3333, 4'hF, 3'b001);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000);
    apb_idle();
  endtask

  task automatic test_back_to_back();
    apb_xfer(1, 1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF, 3'b001);
    apb_xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000);
    apb_xfer(0, 1'b1, 32'h0C, 32'h0BAD_CAFE, 4'hF, 3'b001);
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000);
    apb_idle();
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0C; pwdata = 32'h5555_5555; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    psel_a = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_quiet("abort_outputs");
    end
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000);
    apb_idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h08; pwdata = 32'h7777_7777; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet("reset_mid_outputs");
    check_ctrl("reset_mid_ctrl", ctrl_a, 32'h0);
    psel_a = 1'b0; penable = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_ctrl("ctrl_after_reset_release", ctrl_a, 32'h0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000);
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000);
    apb_idle();
  endtask

  task automatic test_no_setup();
    @(posedge clk); #1;
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_quiet("no_setup_ignored");
    end
    apb_idle();
    apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    apb_idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int unsigned which;
      logic [31:0] addr;
      which = $urandom_range(0, 1);
      addr = 32'($urandom_range(0, 16)) << 2;
      status_in = $urandom;
      apb_xfer(which, 1'($urandom_range(0, 1)), addr, $urandom,
               4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    end
    apb_idle();
    check_ctrl("random_ctrl_a", ctrl_a, model[0][2]);
    check_ctrl("random_ctrl_b", ctrl_b, model[1][2]);
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_write_strobes();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_no_setup();
    test_random();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
